voice_fx_engine: RTL

VOICE_FX_ENGINE -- requirements
Module: voice_fx_engine

---
 rtl/voice_pkg.sv | 23 ++
 rtl/audio_ring_ram.sv | 25 ++
 rtl/voice_fx_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared types and constants for the voice effects engine: effect mode
// encodings, frame sequencer states and default pitch-shift steps.
package voice_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_PITCH_UP = 2'd1,
    MODE_PITCH_DN = 2'd2,
    MODE_ECHO     = 2'd3
  } fx_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_UPD  = 2'd3
  } fx_state_t;

  // Read-pointer steps in unsigned Q.8: 1.5 and ~0.668 samples per frame.
  localparam int DEF_STEP_UP = 384;
  localparam int DEF_STEP_DN = 171;

endpackage

// File: rtl/audio_ring_ram.sv
// Per-channel ring storage: one write and one synchronous read per clock.
// A read of the address being written returns the previous contents.
module audio_ring_ram #(
  parameter int DW    = 16,
  parameter int AW    = 11,
  parameter int WORDS = 2048
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/voice_fx_engine.sv
// Frame-based voice effects: bypass, pitch up/down via fractional ring-buffer
// read pointer, and saturating echo. One frame per new_frame strobe.
module voice_fx_engine
  import voice_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int SLOT       = 24,
  parameter int DW         = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int STEP_UP    = DEF_STEP_UP,
  parameter int STEP_DN    = DEF_STEP_DN,
  parameter int ECHO_DLY   = 512,
  parameter int ECHO_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_frame,
  input  logic [NCH*SLOT-1:0]   rec_data,
  input  logic                  change_en,
  input  logic [1:0]            mode,
  output logic [NCH*SLOT-1:0]   play_data,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun,
  output logic                  primed,
  output logic [DEPTH_LOG2:0]   sample_count
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW    = CW + DEPTH_LOG2;
  localparam int RW    = DEPTH_LOG2 + 8;
  localparam int PAD   = SLOT - DW;

  fx_state_t state_reg, state_next;
  fx_mode_t  eff_mode_reg, prev_mode_reg, req_mode;

  logic                  sync1_reg, sync2_reg, sync3_reg, start_reg;
  logic [CW-1:0]         ch_reg;
  logic [DEPTH_LOG2-1:0] wptr_reg, rd_idx;
  logic [RW-1:0]         rptr_reg, rptr_step;
  logic [DEPTH_LOG2:0]   sample_count_reg;
  logic                  primed_reg, frame_done_reg, overrun_reg;
  logic [SLOT-1:0]       x_reg, slot_out;
  logic [SLOT-1:0]       rec_slot [NCH];
  logic [SLOT-1:0]       out_slot_reg [NCH];
  logic [NCH*SLOT-1:0]   frame_out, play_data_reg;

  logic                  ram_we;
  logic [AW-1:0]         ram_waddr, ram_raddr;
  logic [DW-1:0]         ram_rdata;

  logic [DW-1:0]         x_s, y_proc, echo_sat;
  logic signed [DW-1:0]  tap;
  logic [DW:0]           echo_sum;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
    assign rec_slot[gi]                 = rec_data[gi*SLOT +: SLOT];
    assign frame_out[gi*SLOT +: SLOT]   = out_slot_reg[gi];
  end

  assign req_mode = change_en ? fx_mode_t'(mode) : MODE_BYPASS;

  // new_frame is asynchronous: two-flop synchroniser, then edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      sync1_reg <= new_frame;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      start_reg <= sync2_reg & ~sync3_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_reg) state_next = ST_WR;
      ST_WR:   state_next = ST_RD;
      ST_RD:   state_next = (ch_reg == CW'(NCH-1)) ? ST_UPD : ST_WR;
      ST_UPD:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (eff_mode_reg)
      MODE_PITCH_UP, MODE_PITCH_DN: rd_idx = rptr_reg[RW-1:8];
      MODE_ECHO:                    rd_idx = wptr_reg - DEPTH_LOG2'(ECHO_DLY);
      default:                      rd_idx = wptr_reg;
    endcase
    ram_we    = (state_reg == ST_WR);
    ram_waddr = {ch_reg, wptr_reg};
    ram_raddr = {ch_reg, rd_idx};
    busy      = (state_reg != ST_IDLE);
  end

  audio_ring_ram #(
    .DW    (DW),
    .AW    (AW),
    .WORDS (NCH*DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (rec_slot[ch_reg][SLOT-1 -: DW]),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign x_s      = x_reg[SLOT-1 -: DW];
  assign tap      = $signed(ram_rdata) >>> ECHO_SHIFT;
  assign echo_sum = {x_s[DW-1], x_s} + {tap[DW-1], tap};
  assign echo_sat = (echo_sum[DW] != echo_sum[DW-1])
                    ? (echo_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                    : echo_sum[DW-1:0];

  always_comb begin
    case (eff_mode_reg)
      MODE_PITCH_UP, MODE_PITCH_DN: y_proc = ram_rdata;
      MODE_ECHO:                    y_proc = echo_sat;
      default:                      y_proc = x_s;
    endcase
    if (eff_mode_reg == MODE_BYPASS) begin
      slot_out = x_reg;
    end else if (primed_reg) begin
      slot_out = {y_proc, {PAD{1'b0}}};
    end else begin
      slot_out = {x_s, {PAD{1'b0}}};
    end
    case (eff_mode_reg)
      MODE_PITCH_UP: rptr_step = RW'(STEP_UP);
      MODE_PITCH_DN: rptr_step = RW'(STEP_DN);
      default:       rptr_step = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_reg           <= '0;
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      sample_count_reg <= '0;
      primed_reg       <= 1'b0;
      frame_done_reg   <= 1'b0;
      overrun_reg      <= 1'b0;
      play_data_reg    <= '0;
      x_reg            <= '0;
      eff_mode_reg     <= MODE_BYPASS;
      prev_mode_reg    <= MODE_BYPASS;
      for (int i = 0; i < NCH; i++) out_slot_reg[i] <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      overrun_reg    <= start_reg && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (start_reg) begin
            ch_reg       <= '0;
            eff_mode_reg <= req_mode;
            // Restart the pitch pointer half a buffer behind the writer.
            if (req_mode != prev_mode_reg) begin
              rptr_reg <= {wptr_reg - DEPTH_LOG2'(DEPTH/2), 8'h00};
            end
          end
        end
        ST_WR: x_reg <= rec_slot[ch_reg];
        ST_RD: begin
          out_slot_reg[ch_reg] <= slot_out;
          ch_reg               <= ch_reg + 1'b1;
        end
        ST_UPD: begin
          play_data_reg  <= frame_out;
          frame_done_reg <= 1'b1;
          wptr_reg       <= wptr_reg + 1'b1;
          rptr_reg       <= rptr_reg + rptr_step;
          prev_mode_reg  <= eff_mode_reg;
          if (sample_count_reg != (DEPTH_LOG2+1)'(DEPTH)) begin
            sample_count_reg <= sample_count_reg + 1'b1;
          end
          if (sample_count_reg == (DEPTH_LOG2+1)'(DEPTH-1)) begin
            primed_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign play_data    = play_data_reg;
  assign frame_done   = frame_done_reg;
  assign overrun      = overrun_reg;
  assign primed       = primed_reg;
  assign sample_count = sample_count_reg;

endmodule
